// File: rtl/pb_event_classifier.sv
// Push-button press classifier: SHORT / LONG / DOUBLE from a debounced level,
// delivered one event at a time over a valid/ack slot with sticky overrun.
module pb_event_classifier #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pb_level,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_HOLD,
    S_GAP,
    S_PRESS2
  } state_e;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_prev_q;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             evt_overrun_q, evt_overrun_d;
  logic             busy_q, busy_d;

  logic       rise;
  logic       fall;
  logic       emit;
  logic [1:0] emit_code;
  logic       ack_fire;

  assign rise = pb_level & ~pb_prev_q;
  assign fall = ~pb_level & pb_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = EVT_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS1;
          cnt_d   = '0;
        end
      end
      S_PRESS1: begin
        if (fall) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_d   = S_HOLD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (fall) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        // A second press wins even on the timeout cycle
        if (rise) begin
          state_d = S_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESS2: begin
        if (fall) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_d   = S_HOLD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ack_fire = evt_valid_q & evt_ack;

  always_comb begin
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_overrun_d = evt_overrun_q;
    if (ack_fire) begin
      evt_valid_d   = 1'b0;
      evt_code_d    = EVT_NONE;
      evt_overrun_d = 1'b0;
    end
    if (emit) begin
      if (!evt_valid_q || ack_fire) begin
        evt_valid_d   = 1'b1;
        evt_code_d    = emit_code;
        evt_overrun_d = 1'b0;
      end else begin
        evt_overrun_d = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  // pb_prev resets high so a button held through reset needs a fresh press
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pb_prev_q     <= 1'b1;
      evt_valid_q   <= 1'b0;
      evt_code_q    <= EVT_NONE;
      evt_overrun_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pb_prev_q     <= pb_level;
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_overrun_q <= evt_overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_overrun = evt_overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pb_event_classifier.sv
// Directed bench for pb_event_classifier with small LONG/GAP limits.
// Rows give inputs for one cycle and outputs expected just after that edge.
module tb_pb_event_classifier;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pb_level;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pb;
    logic       ack;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  pb_event_classifier #(
    .LONG_CYCLES(8),
    .GAP_CYCLES (4),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pb_level   (pb_level),
    .evt_ack    (evt_ack),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_overrun(evt_overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic pb, input logic ack,
                              input logic v, input logic [1:0] c,
                              input logic ov, input logic b);
    vec_t t;
    t.pb  = pb;
    t.ack = ack;
    t.exp = {v, c, ov, b};
    tbl.push_back(t);
  endfunction

  function automatic void addn(input int n, input logic pb,
                               input logic ack, input logic v,
                               input logic [1:0] c, input logic ov,
                               input logic b);
    for (int k = 0; k < n; k++) add(pb, ack, v, c, ov, b);
  endfunction

  task automatic drive(input logic pb, input logic ack);
    pb_level = pb;
    evt_ack  = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {evt_valid, evt_code, evt_overrun, busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s v/code/ovr/busy got %b required %b",
               name, act, exp);
    end
  endtask

  initial begin
    // short press: high 3, gap times out after 4 low cycles
    addn(3, 1, 0, 0, 2'b00, 0, 1);
    addn(4, 0, 0, 0, 2'b00, 0, 1);
    add (0, 0, 1, 2'b01, 0, 0);
    add (0, 1, 0, 2'b00, 0, 0);
    // double press: high 2, low 2, high 2, low
    addn(2, 1, 0, 0, 2'b00, 0, 1);
    addn(2, 0, 0, 0, 2'b00, 0, 1);
    addn(2, 1, 0, 0, 2'b00, 0, 1);
    add (0, 0, 1, 2'b11, 0, 0);
    add (0, 1, 0, 2'b00, 0, 0);
    addn(4, 0, 1, 0, 2'b00, 0, 0);
    // double with second rise on the gap timeout cycle
    add (1, 0, 0, 2'b00, 0, 1);
    addn(4, 0, 0, 0, 2'b00, 0, 1);
    add (1, 0, 0, 2'b00, 0, 1);
    add (0, 0, 1, 2'b11, 0, 0);
    add (0, 1, 0, 2'b00, 0, 0);
    // long press held 20 cycles, nothing on release
    addn(8, 1, 0, 0, 2'b00, 0, 1);
    addn(12, 1, 0, 1, 2'b10, 0, 1);
    add (0, 0, 1, 2'b10, 0, 0);
    add (0, 1, 0, 2'b00, 0, 0);
    add (0, 0, 0, 2'b00, 0, 0);
    // double then hold: DOUBLE once, HOLD until release
    add (1, 0, 0, 2'b00, 0, 1);
    add (0, 0, 0, 2'b00, 0, 1);
    add (1, 0, 0, 2'b00, 0, 1);
    addn(7, 1, 0, 0, 2'b00, 0, 1);
    add (1, 0, 1, 2'b11, 0, 1);
    add (1, 0, 1, 2'b11, 0, 1);
    add (0, 0, 1, 2'b11, 0, 0);
    add (0, 1, 0, 2'b00, 0, 0);
    // two shorts without ack -> overrun, then LONG loads with same-cycle ack
    addn(3, 1, 0, 0, 2'b00, 0, 1);
    addn(4, 0, 0, 0, 2'b00, 0, 1);
    add (0, 0, 1, 2'b01, 0, 0);
    addn(3, 1, 0, 1, 2'b01, 0, 1);
    addn(4, 0, 0, 1, 2'b01, 0, 1);
    add (0, 0, 1, 2'b01, 1, 0);
    addn(8, 1, 0, 1, 2'b01, 1, 1);
    add (1, 1, 1, 2'b10, 0, 1);
    add (0, 0, 1, 2'b10, 0, 0);
    add (0, 1, 0, 2'b00, 0, 0);
    // overrun cleared by a plain ack
    addn(3, 1, 0, 0, 2'b00, 0, 1);
    addn(4, 0, 0, 0, 2'b00, 0, 1);
    add (0, 0, 1, 2'b01, 0, 0);
    addn(3, 1, 0, 1, 2'b01, 0, 1);
    addn(4, 0, 0, 1, 2'b01, 0, 1);
    add (0, 0, 1, 2'b01, 1, 0);
    add (0, 1, 0, 2'b00, 0, 0);

    resetn   = 1'b0;
    pb_level = 1'b0;
    evt_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 5'b0_00_0_0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0);
    chk("idle_after_reset", 5'b0_00_0_0);

    foreach (tbl[i]) begin
      drive(tbl[i].pb, tbl[i].ack);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // async reset mid-press with an event pending
    repeat (3) drive(1, 0);
    repeat (5) drive(0, 0);
    chk("pre_reset_evt", 5'b1_01_0_0);
    drive(1, 0);
    chk("pre_reset_busy", 5'b1_01_0_1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset", 5'b0_00_0_0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(1, 0);
      chk($sformatf("held_ignored%0d", k), 5'b0_00_0_0);
    end
    drive(0, 0);
    chk("release_idle", 5'b0_00_0_0);
    drive(1, 0);
    chk("new_press", 5'b0_00_0_1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
